// File: rtl/tdm_pkg.sv
// Shared types and sizes for the 4-channel TDM demultiplexer.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SLOT_W = 2;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage : tdm_pkg

// File: rtl/demux_1x4.sv
// Combinational 1:4 enable steering, built as a 2:1 tree matching the transmit-side mux.
module demux_1x4
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0] slot,
    input  logic              en,
    output logic [NUM_CH-1:0] ch_en_c
);

    logic lo_en;
    logic hi_en;

    // First stage splits on the slot MSB, second stage on the LSB.
    always_comb begin
        lo_en      = en & ~slot[1];
        hi_en      = en &  slot[1];
        ch_en_c[0] = lo_en & ~slot[0];
        ch_en_c[1] = lo_en &  slot[0];
        ch_en_c[2] = hi_en & ~slot[0];
        ch_en_c[3] = hi_en &  slot[0];
    end

endmodule : demux_1x4

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM receive demultiplexer with slot tracking, frame lock and framing-error detection.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [3:0]       ch_valid,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    state_t            state_q;
    state_t            state_d;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] slot_d;
    logic              cap_en;
    logic [SLOT_W-1:0] cap_slot;
    logic              err_d;
    logic              fv_d;
    logic [NUM_CH-1:0] ch_en_c;
    logic [WIDTH-1:0]  d_q [NUM_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next state and slot; only valid words move the frame position.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        state_d = LOCK;
                        slot_d  = SLOT_W'(1);
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        slot_d = SLOT_W'(1);
                    end else if (slot_q == '0) begin
                        state_d = HUNT;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // Capture request and pulse values for the word presented this cycle.
    always_comb begin
        cap_en   = 1'b0;
        cap_slot = slot_q;
        err_d    = 1'b0;
        fv_d     = 1'b0;
        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        cap_en   = 1'b1;
                        cap_slot = '0;
                    end
                end
                LOCK: begin
                    if (frame_sync) begin
                        cap_en   = 1'b1;
                        cap_slot = '0;
                        err_d    = (slot_q != '0);
                    end else if (slot_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cap_en = 1'b1;
                        fv_d   = (slot_q == SLOT_W'(3));
                    end
                end
                default: ;
            endcase
        end
    end

    demux_1x4 u_demux (
        .slot    (cap_slot),
        .en      (cap_en),
        .ch_en_c (ch_en_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) d_q[i] <= '0;
            ch_valid    <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_en_c[i]) d_q[i] <= din;
            end
            ch_valid    <= ch_en_c;
            frame_valid <= fv_d;
            locked      <= (state_d == LOCK);
            sync_err    <= err_d;
        end
    end

    assign d0 = d_q[0];
    assign d1 = d_q[1];
    assign d2 = d_q[2];
    assign d3 = d_q[3];

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
// Directed bench for tdm_demux_4ch with a behavioural frame model checked every cycle.
module tb_tdm_demux_4ch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] ch_valid;
    logic       frame_valid, locked, sync_err;

    int checks = 0;
    int errors = 0;

    tdm_demux_4ch #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .ch_valid(ch_valid), .frame_valid(frame_valid), .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Model state: alignment flag, expected slot, channel contents and pulses.
    bit       m_lock;
    int       m_slot;
    bit [7:0] m_d [4];
    bit [3:0] e_cv;
    bit       e_fv, e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lock = 0; m_slot = 0; e_cv = 0; e_fv = 0; e_err = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 0;
        end else begin
            e_cv = 0; e_fv = 0; e_err = 0;
            if (din_valid) begin
                if (!m_lock) begin
                    if (frame_sync) begin
                        m_d[0] = din; e_cv = 4'b0001; m_lock = 1; m_slot = 1;
                    end
                end else if (frame_sync) begin
                    if (m_slot != 0) e_err = 1;
                    m_d[0] = din; e_cv = 4'b0001; m_slot = 1;
                end else if (m_slot == 0) begin
                    e_err = 1; m_lock = 0;
                end else begin
                    m_d[m_slot] = din;
                    e_cv = 4'(1 << m_slot);
                    if (m_slot == 3) e_fv = 1;
                    m_slot = (m_slot + 1) % 4;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_d0", 32'(d0), 32'(m_d[0]));
        chk("model_d1", 32'(d1), 32'(m_d[1]));
        chk("model_d2", 32'(d2), 32'(m_d[2]));
        chk("model_d3", 32'(d3), 32'(m_d[3]));
        chk("model_ch_valid", 32'(ch_valid), 32'(e_cv));
        chk("model_frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("model_locked", 32'(locked), 32'(m_lock));
        chk("model_sync_err", 32'(sync_err), 32'(e_err));
    end

    task automatic send(input logic [7:0] w, input logic s);
        din = w; frame_sync = s; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        chk("reset_locked", 32'(locked), 0);
        chk("reset_ch_valid", 32'(ch_valid), 0);
        chk("reset_d0", 32'(d0), 0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);
    endtask

    initial begin
        din = '0; din_valid = 1'b0; frame_sync = 1'b0; rst_n = 1'b0;
        do_reset();

        // Aligned back-to-back frame
        send(8'h10, 1); chk("al_cv0", 32'(ch_valid), 4'b0001); chk("al_lock", 32'(locked), 1);
        send(8'h11, 0); chk("al_cv1", 32'(ch_valid), 4'b0010);
        send(8'h12, 0); chk("al_cv2", 32'(ch_valid), 4'b0100);
        send(8'h13, 0); chk("al_cv3", 32'(ch_valid), 4'b1000); chk("al_fv", 32'(frame_valid), 1);
        chk("al_d0", 32'(d0), 8'h10); chk("al_d1", 32'(d1), 8'h11);
        chk("al_d2", 32'(d2), 8'h12); chk("al_d3", 32'(d3), 8'h13);
        idle(1); chk("al_fv_gone", 32'(frame_valid), 0);

        // Gapped frame
        send(8'h14, 1); chk("gap_cv0", 32'(ch_valid), 4'b0001);
        idle(3); chk("gap_idle_cv", 32'(ch_valid), 0);
        send(8'h15, 0); idle(3);
        send(8'h16, 0); idle(3);
        send(8'h17, 0); chk("gap_fv", 32'(frame_valid), 1); chk("gap_d3", 32'(d3), 8'h17);
        idle(3); chk("gap_lock", 32'(locked), 1);

        // Hunt discard
        do_reset();
        send(8'h55, 0); chk("hunt_cv_55", 32'(ch_valid), 0);
        send(8'h66, 0); chk("hunt_cv_66", 32'(ch_valid), 0); chk("hunt_unlocked", 32'(locked), 0);
        send(8'h77, 1); chk("hunt_d0", 32'(d0), 8'h77); chk("hunt_lock", 32'(locked), 1);
        send(8'h78, 0); send(8'h79, 0); send(8'h7a, 0);

        // Early sync at slot 2
        send(8'h20, 1); send(8'h21, 0);
        send(8'h30, 1);
        chk("early_err", 32'(sync_err), 1); chk("early_cv", 32'(ch_valid), 4'b0001);
        chk("early_d0", 32'(d0), 8'h30); chk("early_d1", 32'(d1), 8'h21);
        chk("early_fv", 32'(frame_valid), 0); chk("early_lock", 32'(locked), 1);
        send(8'h31, 0); chk("early_next_d1", 32'(d1), 8'h31); chk("early_next_cv", 32'(ch_valid), 4'b0010);

        // Missing sync at slot 0
        send(8'h32, 0); send(8'h33, 0);
        send(8'h40, 0);
        chk("miss_err", 32'(sync_err), 1); chk("miss_lock", 32'(locked), 0);
        chk("miss_d0", 32'(d0), 8'h30); chk("miss_cv", 32'(ch_valid), 0);
        send(8'h41, 0); chk("miss_ignored_cv", 32'(ch_valid), 0); chk("miss_d1", 32'(d1), 8'h31);

        // Reset between clock edges mid-frame
        send(8'h10, 1); send(8'h11, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_d0", 32'(d0), 0); chk("rst_mid_d1", 32'(d1), 0);
        chk("rst_mid_lock", 32'(locked), 0); chk("rst_mid_cv", 32'(ch_valid), 0);
        @(negedge clk); rst_n = 1'b1;
        idle(1);
        send(8'h12, 0);
        chk("rst_after_cv", 32'(ch_valid), 0); chk("rst_after_d2", 32'(d2), 0);
        chk("rst_after_lock", 32'(locked), 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tdm_demux_4ch
